// File: rtl/wisc_defs.sv
// Shared WISC definitions: opcode constants, default NOP word and fetch FSM encoding.
package wisc_defs;

    localparam logic [3:0]  OPC_B   = 4'hC;
    localparam logic [3:0]  OPC_BR  = 4'hD;
    localparam logic [3:0]  OPC_HLT = 4'hF;

    localparam logic [15:0] NOP_INSTR_DFLT = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:12] == OPC_HLT;
    endfunction

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder/subtractor built from four 4-bit lookahead groups.
module CLA_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Sub,
    output logic [15:0] Sum
);

    logic [15:0] w_b;
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [2:0]  w_gg;
    logic [2:0]  w_gp;
    logic [3:0]  w_gc;

    always_comb begin
        w_b  = B ^ {16{Sub}};
        w_g  = A & w_b;
        w_p  = A ^ w_b;
        w_c  = '0;
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        for (int k = 0; k < 3; k++) begin
            w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | ((&w_p[4*k+3 -: 3]) & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end
        // Group carries are fully expanded so no group waits on its neighbour.
        w_gc[0] = Sub;
        w_gc[1] = w_gg[0] | (w_gp[0] & Sub);
        w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & Sub);
        w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[2] & w_gp[1] & w_gp[0] & Sub);
        for (int k = 0; k < 4; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
        end
        Sum = w_p ^ w_c;
    end

endmodule

// File: rtl/fetch_hold_buf.sv
// Single-entry skid register holding an instruction word and its PC+2 while IF/ID is stalled.
module fetch_hold_buf
    import wisc_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [15:0] i_instr,
    input  logic [15:0] i_pc2,
    output logic        o_valid,
    output logic [15:0] o_instr,
    output logic [15:0] o_pc2
);

    logic        r_valid;
    logic [15:0] r_instr;
    logic [15:0] r_pc2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR_DFLT;
            r_pc2   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc2   <= i_pc2;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc2   = r_pc2;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns the PC, talks to a variable-latency imem, loads IF/ID.
module fetch_stage
    import wisc_defs::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_next,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_q,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        halted
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [15:0]  r_pc;
    logic [15:0]  w_pc_nxt;
    logic [15:0]  r_ifid_instr;
    logic [15:0]  w_ifid_instr_nxt;
    logic [15:0]  r_ifid_pc2;
    logic [15:0]  w_ifid_pc2_nxt;
    logic         r_ifid_valid;
    logic         w_ifid_valid_nxt;

    logic [15:0]  w_pc2;
    logic         w_req;
    logic         w_accept;
    logic         w_deliver;
    logic [15:0]  w_word;
    logic [15:0]  w_word_pc2;
    logic         w_hb_load;
    logic         w_hb_clear;
    logic         w_hb_valid;
    logic [15:0]  w_hb_instr;
    logic [15:0]  w_hb_pc2;

    CLA_16bit u_pc_add (
        .A   (r_pc),
        .B   (16'h0002),
        .Sub (1'b0),
        .Sum (w_pc2)
    );

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_hb_load),
        .i_clear (w_hb_clear),
        .i_instr (imem_data),
        .i_pc2   (w_pc2),
        .o_valid (w_hb_valid),
        .o_instr (w_hb_instr),
        .o_pc2   (w_hb_pc2)
    );

    // Gated by rst_n so no request leaks out while the stage is held in reset.
    assign w_req = rst_n & (((r_state == FETCH) & ~w_hb_valid & ~stall)
                          | (r_state == WAIT) | (r_state == DRAIN));
    assign w_accept   = w_req & imem_ready & ((r_state == FETCH) | (r_state == WAIT));
    assign w_deliver  = (r_state == FETCH) & w_hb_valid & ~stall;
    assign w_word     = w_deliver ? w_hb_instr : imem_data;
    assign w_word_pc2 = w_deliver ? w_hb_pc2 : w_pc2;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc2_nxt   = r_ifid_pc2;
        w_ifid_valid_nxt = r_ifid_valid;
        w_hb_load        = 1'b0;
        w_hb_clear       = 1'b0;

        if (flush) begin
            w_pc_nxt   = pc_next;
            w_hb_clear = 1'b1;
            // IF/ID is already a bubble in DRAIN; only the PC moves.
            if (r_state != DRAIN) begin
                w_ifid_instr_nxt = NOP_INSTR;
                w_ifid_pc2_nxt   = '0;
                w_ifid_valid_nxt = 1'b0;
            end
            w_state_nxt = (w_req && !imem_ready) ? DRAIN : FETCH;
        end else if (w_accept && stall) begin
            w_hb_load   = 1'b1;
            w_state_nxt = FETCH;
        end else if (w_accept || w_deliver) begin
            w_ifid_instr_nxt = w_word;
            w_ifid_pc2_nxt   = w_word_pc2;
            w_ifid_valid_nxt = 1'b1;
            w_pc_nxt         = pc_next;
            w_hb_clear       = w_deliver;
            w_state_nxt      = is_hlt(w_word) ? HALT : FETCH;
        end else if ((r_state == FETCH) && w_req) begin
            w_state_nxt = WAIT;
        end else if ((r_state == DRAIN) && imem_ready) begin
            w_state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc2   <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc2   <= w_ifid_pc2_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign pc_q        = r_pc;
    assign if_id_instr = r_ifid_instr;
    assign if_id_pc2   = r_ifid_pc2;
    assign if_id_valid = r_ifid_valid;
    assign halted      = (r_state == HALT);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit WISC pipeline, directly upstream of PC control.
- Owns the PC register and drives its value to PC control as PC_in.
- Accepts the next PC that PC control computes, issues requests to a variable-latency instruction memory (cache-backed, may stall) and loads the IF/ID pipeline register.
- Handles stall, flush/redirect, in-flight response discard and halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction word placed in IF/ID on a bubble.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_next  in  16  next PC from PC control (PC+2, branch target or register target).
- flush  in  1  taken branch resolved; redirect to pc_next and squash IF/ID.
- stall  in  1  hazard unit hold request for IF/ID and PC.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  16  read address, always equal to pc_q.
- imem_ready  in  1  response valid for the oldest outstanding request.
- imem_data  in  16  instruction word, valid with imem_ready.
- pc_q  out  16  current PC, drives PC control PC_in.
- if_id_instr  out  16  IF/ID instruction.
- if_id_pc2  out  16  IF/ID PC+2 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  HLT fetched; fetch frozen.

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - pc_q=RESET_PC, state=FETCH.
  - if_id_instr=NOP_INSTR, if_id_pc2=0, if_id_valid=0.
  - halted=0, hold buffer empty.
  - imem_req=0 while rst_n=0.
- States: FETCH, WAIT, DRAIN, HALT.
- imem_req is asserted in FETCH when the hold buffer is empty and stall=0, and in WAIT and DRAIN. imem_addr=pc_q in all states.
- FETCH:
  - A request with imem_ready in the same cycle is an accept; the hit path has 1-cycle latency into IF/ID.
  - A request without imem_ready goes to WAIT.
- WAIT: imem_req stays high with the address held; imem_ready is an accept.
- Accept with stall=0:
  - IF/ID <= {imem_data, pc_q+2}, if_id_valid=1.
  - pc_q <= pc_next.
  - If imem_data[15:12]==OPC_HLT, the next state is HALT; otherwise FETCH.
- Accept with stall=1:
  - The word goes into the single-entry hold buffer; PC and IF/ID are held; the state is FETCH.
  - While the buffer is full, no request is issued.
  - In the first cycle with stall=0, the buffer is delivered to IF/ID exactly as an accept would be, including the HLT check and the pc_q update.
- stall=1 with no accept: IF/ID and pc_q are held. An outstanding WAIT request stays outstanding and is not re-issued.
- flush (priority over stall and accept):
  - pc_q <= pc_next.
  - IF/ID <= {NOP_INSTR, 0}, if_id_valid=0.
  - The hold buffer is cleared and halted is cleared.
  - If a request is outstanding and imem_ready has not arrived in this cycle, the next state is DRAIN; otherwise FETCH.
- DRAIN: keep imem_req until imem_ready, discard the data, then go to FETCH. A flush in DRAIN updates pc_q only.
- HALT:
  - halted=1, imem_req=0; pc_q and IF/ID are frozen, with the HLT instruction left in IF/ID.
  - Only a flush exits HALT (HLT fetched in a branch shadow), to FETCH at pc_next.
- pc_q+2 uses a 16-bit wrap-around add: 16'hFFFE+2=16'h0000. There is no overflow output.
- Reset asserted mid-WAIT abandons the request; memory discards its own state on the same reset.
- At most one request is outstanding at any time.

Decomposition:
- Shared package wisc_defs holds:
  - opcode constants OPC_B=4'hC, OPC_BR=4'hD, OPC_HLT=4'hF;
  - NOP_INSTR default;
  - the fetch state encoding (2-bit enum FETCH/WAIT/DRAIN/HALT).
- The PC+2 adder reuses the existing CLA_16bit (Sub=0); no new adder.
- One sub-module is natural: fetch_hold_buf, the single-entry instruction/PC skid register with valid.

Test Plan:
- Reset then 3 single-cycle hits at 0x0000, 0x0002, 0x0004 -> IF/ID pc2 = 0x0002, 0x0004, 0x0006 on consecutive cycles; if_id_valid=1 from the first edge after the first request.
- Miss at 0x0010 with imem_ready after 4 cycles -> imem_addr held at 0x0010 for 4 cycles, IF/ID updates once, pc_q=pc_next afterwards.
- Response arrives while stall=1 -> word held in buffer, imem_req=0; stall drops -> IF/ID loads the word with no new request issued.
- flush with pc_next=0x0040 while in WAIT -> DRAIN; the late response is discarded; next request has imem_addr=0x0040; if_id_valid=0 for the bubble.
- Fetch 16'hF000 (HLT) -> halted=1 the next cycle, imem_req stays 0 and pc_q is constant for 10 cycles; then flush to 0x0020 -> fetch resumes at 0x0020.
- pc_q=16'hFFFE hit with pc_next=0x0000 -> if_id_pc2=0x0000; rst_n pulsed low mid-WAIT -> all outputs return to reset values immediately.
